// File: rtl/nbit_accumulator_pkg.sv
// Shared definitions for the accumulator stage on the ALU result path:
// the FSM state encoding and the default datapath width.
package nbit_accumulator_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic {
    ACC_ST_ACCUM = 1'b0,
    ACC_ST_DONE  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/nbit_adder.sv
// Combinational unsigned WIDTH-bit adder. Callers that need the carry widen
// the operands by one bit and read it from the MSB of the sum.
module nbit_adder #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] sum
);

  assign sum = i1 + i2;

endmodule

// File: rtl/nbit_accumulator.sv
// Sums COUNT words per burst over valid/ready and presents the modulo sum with
// a sticky carry-out flag. The handshake outputs are decoded from state only.
module nbit_accumulator
  import nbit_accumulator_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(COUNT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  acc_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic [WIDTH:0]   adder_out;

  nbit_adder #(
    .WIDTH(WIDTH + 1)
  ) u_adder (
    .i1 ({1'b0, acc_q}),
    .i2 ({1'b0, in_word}),
    .sum(adder_out)
  );

  assign in_ready  = (state_q == ACC_ST_ACCUM);
  assign out_valid = (state_q == ACC_ST_DONE);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;

    if (clear) begin
      state_d = ACC_ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACC_ST_ACCUM: begin
          if (in_valid) begin
            acc_d = adder_out[WIDTH-1:0];
            ovf_d = ovf_q | adder_out[WIDTH];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              out_sum_d = adder_out[WIDTH-1:0];
              out_ovf_d = ovf_q | adder_out[WIDTH];
              state_d   = ACC_ST_DONE;
            end
          end
        end
        ACC_ST_DONE: begin
          // The input side stays stalled in this cycle even if a word is offered.
          if (out_ready) begin
            state_d = ACC_ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACC_ST_ACCUM;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC_ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_nbit_accumulator.sv
// Self-checking bench for nbit_accumulator: a COUNT=4 and a COUNT=1 instance,
// table-driven bursts plus hand-written handshake, clear and reset sequences.
module tb_nbit_accumulator;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_word = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, out_ovf;
  logic [W-1:0] out_sum;

  logic         clear1 = 1'b0;
  logic         in_valid1 = 1'b0;
  logic [W-1:0] in_word1 = '0;
  logic         out_ready1 = 1'b0;
  logic         in_ready1, out_valid1, out_ovf1;
  logic [W-1:0] out_sum1;

  always #5 clk = ~clk;

  nbit_accumulator #(.WIDTH(W), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  nbit_accumulator #(.WIDTH(W), .COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_word(in_word1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_ovf(out_ovf1)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] w [4];
    logic [W-1:0] sum;
    logic         ovf;
  } vec_t;

  exp_t q[$];
  exp_t q1[$];
  int   passed = 0;
  int   total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard compare at the sample point, then advance one full clock.
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
    if (out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("unexpected_result1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("out_sum1", 32'(out_sum1), 32'(e.sum));
        check("out_ovf1", 32'(out_ovf1), 32'(e.ovf));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] word);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_word  = word;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = in_ready;
      tick();
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    q.push_back(e);
  endtask

  task automatic push1(input logic [W-1:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    q1.push_back(e);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{w: '{16'd138, 16'd299, 16'd72, 16'd29}, sum: 16'd538, ovf: 1'b0};
    vecs[1] = '{w: '{16'hFFFF, 16'h0001, 16'h7FFF, 16'h0000}, sum: 16'h7FFF, ovf: 1'b1};
    vecs[2] = '{w: '{16'd1, 16'd2, 16'd3, 16'd4}, sum: 16'd10, ovf: 1'b0};
    vecs[3] = '{w: '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, sum: 16'hFFFC, ovf: 1'b1};
    vecs[4] = '{w: '{16'h8000, 16'h8000, 16'h0000, 16'h0000}, sum: 16'h0000, ovf: 1'b1};
    vecs[5] = '{w: '{16'd0, 16'd0, 16'd0, 16'd0}, sum: 16'd0, ovf: 1'b0};

    // Reset values.
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven bursts, consumer always ready.
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) send(vecs[v].w[k]);
      push(vecs[v].sum, vecs[v].ovf);
      if (v == 0) begin
        check("latency_out_valid", 32'(out_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
      end
    end
    tick();

    // Backpressure: result held, offered word stalled until handshake.
    out_ready = 1'b0;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    push(16'd10, 1'b0);
    in_valid = 1'b1;
    in_word  = 16'd99;
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum", 32'(out_sum), 32'd10);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    send(16'd1); send(16'd1); send(16'd1);
    push(16'd102, 1'b0);
    tick();

    // clear mid-burst discards 5 and 6 and ignores the word offered with it.
    send(16'd5); send(16'd6);
    clear = 1'b1; in_valid = 1'b1; in_word = 16'd100;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    send(16'd7); send(16'd8); send(16'd9); send(16'd10);
    push(16'd34, 1'b0);
    tick();

    // clear drops a pending result.
    out_ready = 1'b0;
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_drops_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(16'd2); send(16'd2); send(16'd2); send(16'd2);
    push(16'd8, 1'b0);
    tick();

    // Asynchronous reset while a result is pending.
    out_ready = 1'b0;
    send(16'd138); send(16'd299); send(16'd72); send(16'd29);
    check("pre_rst_sum", 32'(out_sum), 32'd538);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_sum", 32'(out_sum), 32'd0);
    check("arst_out_ovf", 32'(out_ovf), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // COUNT=1 instance: back-to-back words with one bubble between accepts.
    out_ready1 = 1'b1;
    in_valid1  = 1'b1;
    in_word1   = 16'd40;
    check("c1_in_ready0", 32'(in_ready1), 32'd1);
    push1(16'd40, 1'b0);
    tick();
    in_word1 = 16'hFFFF;
    check("c1_bubble", 32'(in_ready1), 32'd0);
    check("c1_valid", 32'(out_valid1), 32'd1);
    tick();
    check("c1_in_ready1", 32'(in_ready1), 32'd1);
    push1(16'hFFFF, 1'b0);
    tick();
    in_valid1 = 1'b0;
    tick();
    tick();

    check("sb_empty", 32'(q.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
